// File: rtl/wts_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wts_mixer_pkg
// Brief   : Shared constants, widths and slot-kind type for the 5-channel mixer
// Revision: 1.0 - initial release
// ============================================================================
package wts_mixer_pkg;

  localparam int NUM_CH    = 5;
  localparam int SLOT_END  = 5;
  localparam int ENV_MAX   = 64;
  localparam int ENV_SHIFT = 6;

  localparam int SLOT_W = 3;
  localparam int WAVE_W = 8;
  localparam int ENV_W  = 7;
  localparam int VOL_W  = 4;
  localparam int P1_W   = 14;
  localparam int P2_W   = 18;
  localparam int S2_W   = P2_W - ENV_SHIFT;
  localparam int ACC_W  = 15;

  typedef enum logic [1:0] {
    NOP     = 2'd0,
    CHANNEL = 2'd1,
    END     = 2'd2
  } slot_kind_t;

  function automatic slot_kind_t decode_slot(input logic [SLOT_W-1:0] slot);
    if (int'(slot) < NUM_CH)
      return CHANNEL;
    else if (int'(slot) == SLOT_END)
      return END;
    else
      return NOP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wts_channel_scaler.sv
`default_nettype none
// ============================================================================
// Module  : wts_channel_scaler
// Brief   : Two-stage wave x envelope x volume scaler with slot-kind pipeline
// Revision: 1.0 - initial release
// ============================================================================
module wts_channel_scaler
  import wts_mixer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SLOT_W-1:0]       i_active,
  input  logic [ENV_W-1:0]        i_envelope,
  input  logic [WAVE_W-1:0]       i_wave,
  input  logic [VOL_W-1:0]        i_volume,
  output slot_kind_t              o_kind,
  output logic signed [S2_W-1:0]  o_s2
);

  logic signed [P1_W-1:0] w_p1;
  logic signed [P2_W-1:0] w_p2;
  slot_kind_t             w_kind;

  logic signed [P1_W-1:0] r_p1;
  logic [VOL_W-1:0]       r_vol;
  slot_kind_t             r_kind1;
  logic signed [S2_W-1:0] r_s2;
  slot_kind_t             r_kind2;

  assign w_kind = decode_slot(i_active);

  // Envelope is unsigned: zero-extend it before the signed multiply.
  assign w_p1 = $signed({{(P1_W-WAVE_W){i_wave[WAVE_W-1]}}, i_wave})
              * $signed({{(P1_W-ENV_W){1'b0}}, i_envelope});

  assign w_p2 = $signed({{(P2_W-P1_W){r_p1[P1_W-1]}}, r_p1})
              * $signed({{(P2_W-VOL_W){1'b0}}, r_vol});

  // Dropping the low bits of a two's-complement value is a floor division.
  logic w_unused_lsb;
  assign w_unused_lsb = ^w_p2[ENV_SHIFT-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1    <= '0;
      r_vol   <= '0;
      r_kind1 <= NOP;
      r_s2    <= '0;
      r_kind2 <= NOP;
    end else begin
      r_kind1 <= w_kind;
      if (w_kind == CHANNEL) begin
        r_p1  <= w_p1;
        r_vol <= i_volume;
      end
      r_kind2 <= r_kind1;
      r_s2    <= w_p2[P2_W-1:ENV_SHIFT];
    end
  end

  assign o_kind = r_kind2;
  assign o_s2   = r_s2;

endmodule
`default_nettype wire

// File: rtl/wts_channel_mixer_5ch.sv
`default_nettype none
// ============================================================================
// Module  : wts_channel_mixer_5ch
// Brief   : Scales and accumulates five time-multiplexed channels into one
//           saturated signed mix sample per slot round
// Revision: 1.0 - initial release
// ============================================================================
module wts_channel_mixer_5ch
  import wts_mixer_pkg::*;
#(
  parameter int OUT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SLOT_W-1:0]    active,
  input  logic [ENV_W-1:0]     envelope,
  input  logic [WAVE_W-1:0]    wave,
  input  logic [VOL_W-1:0]     reg_volume_a,
  input  logic [VOL_W-1:0]     reg_volume_b,
  input  logic [VOL_W-1:0]     reg_volume_c,
  input  logic [VOL_W-1:0]     reg_volume_d,
  input  logic [VOL_W-1:0]     reg_volume_e,
  input  logic                 reg_enable_a,
  input  logic                 reg_enable_b,
  input  logic                 reg_enable_c,
  input  logic                 reg_enable_d,
  input  logic                 reg_enable_e,
  output logic [OUT_WIDTH-1:0] mix_out,
  output logic                 mix_valid
);

  localparam int c_sat_max = (2 ** (OUT_WIDTH - 1)) - 1;
  localparam int c_sat_min = -(2 ** (OUT_WIDTH - 1));

  logic [VOL_W-1:0]        w_vol;
  slot_kind_t              w_kind;
  logic signed [S2_W-1:0]  w_s2;
  logic signed [ACC_W-1:0] w_s2_ext;
  logic [OUT_WIDTH-1:0]    w_sat;

  logic signed [ACC_W-1:0] r_acc;
  logic [OUT_WIDTH-1:0]    r_mix_out;
  logic                    r_mix_valid;

  // A disabled channel still occupies its slot but contributes zero.
  always_comb begin
    w_vol = '0;
    case (active)
      3'd0: w_vol = reg_enable_a ? reg_volume_a : '0;
      3'd1: w_vol = reg_enable_b ? reg_volume_b : '0;
      3'd2: w_vol = reg_enable_c ? reg_volume_c : '0;
      3'd3: w_vol = reg_enable_d ? reg_volume_d : '0;
      3'd4: w_vol = reg_enable_e ? reg_volume_e : '0;
      default: w_vol = '0;
    endcase
  end

  wts_channel_scaler u_scaler (
    .clk        (clk),
    .rst        (reset),
    .i_active   (active),
    .i_envelope (envelope),
    .i_wave     (wave),
    .i_volume   (w_vol),
    .o_kind     (w_kind),
    .o_s2       (w_s2)
  );

  assign w_s2_ext = {{(ACC_W-S2_W){w_s2[S2_W-1]}}, w_s2};

  always_comb begin
    w_sat = r_acc[OUT_WIDTH-1:0];
    if (r_acc > c_sat_max)
      w_sat = OUT_WIDTH'(c_sat_max);
    else if (r_acc < c_sat_min)
      w_sat = OUT_WIDTH'(c_sat_min);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
    end else begin
      r_mix_valid <= 1'b0;
      case (w_kind)
        CHANNEL: r_acc <= r_acc + w_s2_ext;
        END: begin
          r_mix_out   <= w_sat;
          r_mix_valid <= 1'b1;
          r_acc       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;

endmodule
`default_nettype wire

// File: doc/wts_channel_mixer_5ch.md
# wts_channel_mixer_5ch

Downstream stage of the 5-channel ADSR envelope generator. Consumes the time-multiplexed `envelope` stream plus the matching per-channel wave sample, scales each by envelope and channel volume, and accumulates the five channels into one saturated signed mix sample per slot round. The output feeds the DAC/output-filter stage.

## Interface
Parameters:
- `OUT_WIDTH`, 12: width of the signed saturated mix output.

Ports:
- `clk`  in  1: single system clock.
- `reset`  in  1: synchronous, active-high reset.
- `active`  in  3: slot index aligned with `envelope`/`wave`. 0..4 select a channel, 5 marks end of round, 6/7 mean no operation.
- `envelope`  in  7: envelope level 0..64 for the slot in `active`.
- `wave`  in  8: signed wave sample for the slot in `active`.
- `reg_volume_a` .. `reg_volume_e`  in  4 each: channel volume 0..15.
- `reg_enable_a` .. `reg_enable_e`  in  1 each: channel enable.
- `mix_out`  out  OUT_WIDTH: signed mixed sample.
- `mix_valid`  out  1: one-cycle pulse when `mix_out` updates.

## Operation
- **S1, registered.** On a channel slot (`active` 0..4):
  - Capture `p1 = wave * envelope` as signed 14b (range -8192..8128).
  - Capture the selected volume, forced to 0 when that channel's enable is 0.
  - Capture `s1_kind` as channel, end, or nop.
- **S2, registered.**
  - Compute `p2 = p1 * volume` as signed 18b.
  - Arithmetic shift right by 6, which is floor division, giving signed 12b (range -1920..1905).
  - Pass `kind` through.
- **Accumulator.** Signed 15b (range -9600..9525).
  - S2 kind=channel: `acc <= acc + s2`.
  - S2 kind=end: load `mix_out` with sat(acc), assert `mix_valid`, and clear `acc` to 0 in the same edge.
  - S2 kind=nop: hold everything.
- **Saturation.** Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. With the default width that is -2048..2047.
- **Input values.**
  - `envelope` values above 64 are used as-is; no clamping.
  - `active` 6/7 are ignored completely: no accumulation, no round end.
- **Non-standard sequences.**
  - Two end markers in a row: the second outputs 0.
  - A channel repeated within a round: it is accumulated twice.
- **Register sampling.** Volume and enable are sampled at S1. A change mid-round affects only slots entering after the change.

## Timing
- **Reset.** `mix_out`=0, `mix_valid`=0, `acc`=0, and both S1 and S2 kind=nop. This applies equally when reset is asserted mid-round: in-flight slots are discarded.
- **Latency.** A slot presented in cycle N reaches S1 at N+1, S2 at N+2, and the accumulator/output at N+3.
  - End marker at N: `mix_out` is valid and `mix_valid`=1 in cycle N+3 only.
- **Throughput.** One slot per cycle, no stalls, no backpressure. The nominal round is 0,1,2,3,4,5, giving `mix_valid` every 6 cycles.
- **Round contents.** Channel 4 entered at N-1 is included in the round closed by the end marker at N.
- **Between rounds.** `mix_out` holds its value between pulses.

## Structure
- **Package `wts_mixer_pkg`.**
  - Constants: `NUM_CH`=5, `SLOT_END`=5, `ENV_MAX`=64, `ENV_SHIFT`=6.
  - Typedef `slot_kind_t` enum {NOP, CHANNEL, END}.
  - Width localparams for `p1`, `p2`, and `acc`.
- **Sub-module `wts_channel_scaler`.** Contains S1/S2: wave × envelope × volume, with shift and kind pipeline.
- **Top.** Holds volume/enable selection, the accumulator, and saturation.

## Test plan
1. Reset, then cycle `active` 0..5 with all enables 0 and `envelope`=64 → `mix_out`=0, `mix_valid` pulses every 6 cycles, 3 cycles after each end slot.
2. Only ch A enabled, `wave`=127, `envelope`=64, vol=15 → 1905. Repeat with `wave`=-128 → -1920.
3. All 5 enabled, `wave`=127, `envelope`=64, vol=15 → sum 9525, saturates to `mix_out`=2047. Repeat with `wave`=-128 → -2048.
4. Floor rounding, ch A, `envelope`=1, vol=1: `wave`=-1 → -1; `wave`=1 → 0. Also `wave`=-1, `envelope`=64, vol=15 → -15.
5. Insert `active`=6/7 between slots and repeat a round → results identical to the round without them. Change vol A 15→0 after slot 0 of a round → the current round still uses 15, the next uses 0.
6. Assert reset at slot 2 and release before slot 3, with ch C/D/E each contributing 100 → `mix_out`=0 during reset, and the first `mix_valid` after release shows only D+E = 200.
